// File: rtl/flappy_pkg.sv
// Shared types and constants for the Flappy Bird game core.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CRASHED = 2'd2
    } state_e;

    // Fibonacci LFSR x^8 + x^6 + x^5 + x^4 + 1: taps on bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_W = width_of(DEF_ROWS);
    localparam int COL_W = width_of(DEF_COLS);

endpackage

// File: rtl/flappy_motion_btn_sync_edge.sv
// Two-flop synchronizer for a raw key followed by a rising-edge pulse.
// The pulse is high for one cycle, two edges after the key is first sampled high.
module btn_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronize the key and keep one cycle of history for edge detection.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/flappy_motion.sv
// Flappy Bird game core: flap conditioning, bird gravity, pipe scroll, pass/crash judge.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for first flap; counters frozen, no gravity/scroll
// RUN     | gravity ticks, pipe scrolls, flaps raise the bird
// CRASHED | ground or pipe hit; everything frozen until ResetGame/Reset
module flappy_motion
    import flappy_pkg::*;
#(
    parameter int ROWS        = DEF_ROWS,
    parameter int COLS        = DEF_COLS,
    parameter int GAP_SIZE    = 3,
    parameter int FLAP_ROWS   = 2,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int PIPE_DIV    = 2,
    parameter int START_ROW   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      button_i,
    input  logic                      reset_game_i,
    output logic [ROWS-1:0]           bird_rows_o,
    output logic [width_of(COLS)-1:0] pipe_col_o,
    output logic [width_of(ROWS)-1:0] gap_row_o,
    output logic                      goal_o,
    output logic                      crash_o
);

    localparam int RW = width_of(ROWS);
    localparam int CW = width_of(COLS);
    localparam int TW = width_of(TICK_CYCLES);
    localparam int DW = width_of(PIPE_DIV);

    localparam logic [RW-1:0]   TOP_ROW   = RW'(ROWS - 1);
    localparam logic [RW-1:0]   START     = RW'(START_ROW);
    localparam logic [RW-1:0]   GAP_MAX   = RW'(ROWS - GAP_SIZE);
    localparam logic [RW-1:0]   GAP_INIT  = RW'(2);
    localparam logic [RW:0]     GAP_SPAN  = (RW + 1)'(GAP_SIZE - 1);
    localparam logic [RW:0]     FLAP_INC  = (RW + 1)'(FLAP_ROWS);
    localparam logic [CW-1:0]   LAST_COL  = CW'(COLS - 1);
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0]   DIV_LAST  = DW'(PIPE_DIV - 1);
    localparam logic [ROWS-1:0] ROW0_BIT  = ROWS'(1);

    state_e          state_q;
    logic [RW-1:0]   bird_q;
    logic [ROWS-1:0] bird_rows_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   gap_q;
    logic            goal_q;
    logic            crash_q;
    logic [TW-1:0]   tick_cnt_q;
    logic [DW-1:0]   div_q;
    logic [7:0]      lfsr_q;

    logic            flap;
    logic            tick;
    logic            pipe_step;
    logic            ground_hit;
    logic            in_gap;
    logic            pipe_crash;
    logic            crash_now;
    logic [RW:0]     raised;
    logic [RW-1:0]   flap_row;
    logic [RW-1:0]   bird_d;
    logic [RW-1:0]   gap_raw;
    logic [RW-1:0]   gap_new;

    btn_sync_edge u_flap_key (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .btn_i  (button_i),
        .pulse_o(flap)
    );

    // Game events and the bird's next row; a flap overrides that tick's gravity.
    always_comb begin
        tick       = (state_q == RUN) && (tick_cnt_q == TICK_LAST);
        pipe_step  = tick && (div_q == DIV_LAST);
        ground_hit = tick && !flap && (bird_q == '0);
        in_gap     = (bird_q >= gap_q) && ({1'b0, bird_q} <= ({1'b0, gap_q} + GAP_SPAN));
        pipe_crash = pipe_step && (col_q == '0) && !in_gap;
        crash_now  = ground_hit || pipe_crash;
        raised     = {1'b0, bird_q} + FLAP_INC;
        flap_row   = (raised > {1'b0, TOP_ROW}) ? TOP_ROW : raised[RW-1:0];
        gap_raw    = lfsr_q[RW-1:0];
        gap_new    = (gap_raw > GAP_MAX) ? GAP_MAX : gap_raw;
        bird_d     = bird_q;
        if (state_q == IDLE) begin
            if (flap) bird_d = flap_row;
        end else if (state_q == RUN && !crash_now) begin
            if (flap) bird_d = flap_row;
            else if (tick) bird_d = bird_q - 1'b1;
        end
    end

    // Free-running gap generator; only a hard reset reseeds it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // Bird row and its one-hot display image, updated together.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || reset_game_i) begin
            bird_q      <= START;
            bird_rows_q <= ROW0_BIT << START;
        end else begin
            bird_q      <= bird_d;
            bird_rows_q <= ROW0_BIT << bird_d;
        end
    end

    // Game state machine: timers, pipe scroll, goal pulse and sticky crash.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || reset_game_i) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            div_q      <= '0;
            col_q      <= LAST_COL;
            gap_q      <= GAP_INIT;
            goal_q     <= 1'b0;
            crash_q    <= 1'b0;
        end else begin
            goal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flap) state_q <= RUN;
                end
                RUN: begin
                    tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
                    if (tick) div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                    if (crash_now) begin
                        state_q <= CRASHED;
                        crash_q <= 1'b1;
                    end else if (pipe_step) begin
                        if (col_q != '0) begin
                            col_q <= col_q - 1'b1;
                        end else begin
                            goal_q <= 1'b1;
                            col_q  <= LAST_COL;
                            gap_q  <= gap_new;
                        end
                    end
                end
                CRASHED: begin
                    crash_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bird_rows_o = bird_rows_q;
    assign pipe_col_o  = col_q;
    assign gap_row_o   = gap_q;
    assign goal_o      = goal_q;
    assign crash_o     = crash_q;

endmodule

// File: tb/tb_flappy_motion.sv
// Directed bench for flappy_motion with TICK_CYCLES=4, PIPE_DIV=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_flappy_motion;
    import flappy_pkg::*;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             button     = 1'b0;
    logic             reset_game = 1'b0;
    logic [7:0]       bird_rows;
    logic [COL_W-1:0] pipe_col;
    logic [ROW_W-1:0] gap_row;
    logic             goal;
    logic             crash;

    int checks   = 0;
    int failures = 0;

    flappy_motion #(
        .TICK_CYCLES(4),
        .PIPE_DIV   (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .button_i    (button),
        .reset_game_i(reset_game),
        .bird_rows_o (bird_rows),
        .pipe_col_o  (pipe_col),
        .gap_row_o   (gap_row),
        .goal_o      (goal),
        .crash_o     (crash)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise the key; the flap lands on the third rising edge, key is then released.
    task automatic press();
        button = 1'b1;
        cyc(3);
        button = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset and idle
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        chk("rst_bird", bird_rows, 8'b0001_0000);
        chk("rst_col", pipe_col, 7);
        chk("rst_gap", gap_row, 2);
        chk("rst_crash", crash, 0);
        chk("rst_goal", goal, 0);
        cyc(20);
        chk("idle_bird", bird_rows, 8'b0001_0000);
        chk("idle_col", pipe_col, 7);

        // Held key -> one flap, then gravity every 4 cycles (F = flap edge)
        button = 1'b1;
        cyc(2);
        chk("flap_latency", bird_rows, 8'b0001_0000);
        cyc(1);
        chk("flap_bird", bird_rows, 8'b0100_0000);
        cyc(7);
        chk("held_once", bird_rows, 8'b0010_0000);
        button = 1'b0;
        cyc(1);
        chk("grav_1", bird_rows, 8'b0001_0000);
        cyc(3);
        chk("grav_hold", bird_rows, 8'b0001_0000);
        cyc(1);
        chk("grav_2", bird_rows, 8'b0000_1000);

        // Flaps coincident with ticks: gravity skipped, top saturation
        cyc(1);
        press();
        chk("coinc_skip", bird_rows, 8'b0010_0000);
        chk("col_t4", pipe_col, 5);
        cyc(4);
        chk("grav_3", bird_rows, 8'b0001_0000);
        cyc(1);
        press();
        chk("coinc_to6", bird_rows, 8'b0100_0000);
        cyc(1);
        press();
        chk("coinc_sat", bird_rows, 8'b1000_0000);
        cyc(4);
        chk("after_sat", bird_rows, 8'b0100_0000);
        chk("col_t8", pipe_col, 3);

        // Steer to row 3 for the column-0 judge against gap 2 -> Goal
        cyc(16);
        press();
        chk("steer_a", bird_rows, 8'b0001_0000);
        cyc(1);
        press();
        chk("steer_b", bird_rows, 8'b0010_0000);
        cyc(8);
        chk("pre_goal_bird", bird_rows, 8'b0000_1000);
        chk("pre_goal_col", pipe_col, 0);
        chk("pre_goal", goal, 0);
        cyc(1);
        chk("goal_pulse", goal, 1);
        chk("goal_col", pipe_col, 7);
        chk("goal_gap_range", (gap_row <= 3'd5), 1);
        chk("goal_bird", bird_rows, 8'b0000_0100);
        chk("goal_crash", crash, 0);
        cyc(1);
        chk("goal_one_cycle", goal, 0);

        // Fall to the ground -> sticky crash
        cyc(10);
        chk("ground_bird", bird_rows, 8'b0000_0001);
        chk("ground_pre", crash, 0);
        cyc(1);
        chk("ground_crash", crash, 1);
        chk("ground_frozen", bird_rows, 8'b0000_0001);
        press();
        cyc(10);
        chk("crash_sticky", crash, 1);
        chk("crash_bird", bird_rows, 8'b0000_0001);
        chk("crash_col", pipe_col, 6);
        chk("crash_goal", goal, 0);
        reset_game = 1'b1;
        cyc(1);
        reset_game = 1'b0;
        chk("rg_bird", bird_rows, 8'b0001_0000);
        chk("rg_crash", crash, 0);
        chk("rg_col", pipe_col, 7);
        chk("rg_gap", gap_row, 2);
        cyc(8);
        chk("rg_idle", bird_rows, 8'b0001_0000);

        // Row 6 at the column-0 judge with gap 2 -> pipe crash, no Goal
        press();
        chk("r2_flap", bird_rows, 8'b0100_0000);
        for (int i = 0; i < 14; i++) begin
            cyc(1);
            press();
        end
        chk("r2_top", bird_rows, 8'b1000_0000);
        chk("r2_col0", pipe_col, 0);
        cyc(4);
        chk("r2_row6", bird_rows, 8'b0100_0000);
        cyc(3);
        chk("r2_pre", crash, 0);
        cyc(1);
        chk("pipe_crash", crash, 1);
        chk("pipe_no_goal", goal, 0);
        cyc(1);
        chk("pipe_no_goal2", goal, 0);
        chk("pipe_sticky", crash, 1);
        reset_game = 1'b1;
        cyc(1);
        reset_game = 1'b0;
        chk("rg2_crash", crash, 0);

        // ResetGame on the edge that would raise Goal -> ResetGame wins
        press();
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            press();
        end
        chk("r3_top", bird_rows, 8'b1000_0000);
        cyc(15);
        chk("r3_row4", bird_rows, 8'b0001_0000);
        chk("r3_col0", pipe_col, 0);
        reset_game = 1'b1;
        cyc(1);
        reset_game = 1'b0;
        chk("collide_goal", goal, 0);
        chk("collide_col", pipe_col, 7);
        chk("collide_gap", gap_row, 2);
        chk("collide_crash", crash, 0);
        cyc(1);
        chk("collide_goal2", goal, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flappy_motion.md
Name: flappy_motion

Overview:
- Upstream game core for the Flappy Bird build.
- Conditions the raw flap button, moves the bird vertically under gravity and flap, scrolls one pipe, and judges pass or crash.
- Each pipe cleared produces a one-cycle Goal pulse for the downstream win/score stage.
- The downstream stage returns ResetGame to start a fresh round.

Parameters:
- ROWS, 8, LED rows in the play column; row 0 = ground.
- COLS, 8, pipe columns; column 0 = bird column.
- GAP_SIZE, 3, rows in the pipe opening.
- FLAP_ROWS, 2, rows gained per flap.
- TICK_CYCLES, 50_000_000, clock cycles per gravity tick.
- PIPE_DIV, 2, gravity ticks per pipe step.
- START_ROW, 4, bird row after reset/ResetGame.

Ports:
- Clock, input, 1: system clock.
- Reset, input, 1: synchronous, active-low reset (0 = reset).
- Button, input, 1: raw asynchronous flap key, active-high.
- ResetGame, input, 1: one-cycle round restart from the downstream win logic.
- BirdRows, output, ROWS: one-hot bird position.
- PipeCol, output, clog2(COLS): current pipe column.
- GapRow, output, clog2(ROWS): lowest open row of the pipe.
- Goal, output, 1: one-cycle pulse, pipe cleared.
- Crash, output, 1: sticky, high in CRASHED.

Behaviour:
- **Reset / ResetGame**
  - Reset low at a Clock edge, or ResetGame high: state=IDLE, bird=START_ROW, PipeCol=COLS-1, GapRow=2, Goal=0, Crash=0, tick counters=0.
  - The LFSR reloads only on Reset (seed 8'hA5), not on ResetGame.
  - Reset has priority over ResetGame. ResetGame has priority over all game events in the same cycle.
- **Button conditioning**
  - Button passes through a 2-flop synchronizer, then a rising-edge detector.
  - flap = one-cycle pulse, 3 cycles after the Button rise.
  - A held Button yields exactly one flap.
- **LFSR**
  - 8-bit Fibonacci, taps 8,6,5,4, advances every cycle, never all-zero.
  - New gap = lfsr[2:0], clamped to ROWS-GAP_SIZE.
- **States**
  - IDLE: counters frozen, no gravity, no scroll. flap -> RUN, and the flap applies in the same cycle.
  - RUN:
    - Tick counter counts 0..TICK_CYCLES-1; tick pulse on wrap.
    - Each tick: bird -= 1 and the pipe divider increments.
    - A tick with bird==0 -> CRASHED (ground hit).
    - flap: bird = min(bird+FLAP_ROWS, ROWS-1), saturating at the top.
    - flap and tick in the same cycle: flap applies, gravity is skipped for that tick, and the tick counter still wraps.
  - Pipe step (every PIPE_DIV-th tick):
    - PipeCol>0: PipeCol -= 1.
    - PipeCol==0: judge the bird row.
      - Row in [GapRow, GapRow+GAP_SIZE-1]: Goal=1 on the next cycle, PipeCol=COLS-1, GapRow=new gap.
      - Otherwise -> CRASHED.
    - Pipe step and ground crash in the same tick: crash wins, no Goal.
  - CRASHED: Crash=1; bird, pipe and Goal frozen; flaps ignored; leave only via ResetGame or Reset.
- **Outputs**
  - All outputs are registered.
  - BirdRows = 1 << bird.
  - Goal never lasts more than one cycle.

Decomposition:
- Package flappy_pkg:
  - state enum {IDLE, RUN, CRASHED}.
  - LFSR seed and taps constants.
  - Shared row/column width localparams.
- One sub-module: btn_sync_edge (2-flop synchronizer plus rising-edge pulse), reused for other keys.

Test Plan:
All scenarios use TICK_CYCLES=4, PIPE_DIV=2, other parameters at defaults.
1. Reset low 3 cycles, Reset high, no Button -> BirdRows=8'b0001_0000, PipeCol=7, GapRow=2, Crash=0, state stays IDLE for 20 cycles.
2. Button rises and is held 10 cycles -> exactly one flap. BirdRows=8'b0100_0000 three cycles after the rise. Then bird drops one row every 4 cycles.
3. From row 6, flap pulse coincident with a tick -> row 7 (saturated, gravity skipped). Next tick -> row 6.
4. No flaps from START_ROW -> row reaches 0. On the next tick Crash=1 and stays high. Later Button presses change nothing. ResetGame pulse -> IDLE, row 4, Crash=0.
5. Force bird row 3 with GapRow=2 when PipeCol steps from 0 -> Goal high for exactly 1 cycle, PipeCol=7, GapRow in 0..5.
6. Bird row 6 with GapRow=2 at the column-0 step -> Crash=1, Goal stays 0. ResetGame and Goal-cycle collision -> ResetGame wins, Goal=0.
